// File: rtl/loop_sampler.sv
// rtl/loop_sampler.sv - ring-oscillator entropy loop controller with von Neumann harvester
// Seeds the loop, samples its synchronised output, debiases pairs and packs 32-bit words.
module loop_sampler #(
    parameter int SAMPLE_CYCLES = 16,
    parameter int SEED_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        loop_d,
    output logic        loop_ctrl,
    output logic        loop_seed,
    output logic [31:0] rnd_data,
    output logic        rnd_valid,
    input  logic        rnd_ack
);

    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0] SEED_LAST   = 8'(SEED_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic [7:0]  seed_cnt;
    logic [7:0]  sample_cnt;
    logic        pair_flag;
    logic        first_bit;
    logic [31:0] collect;
    logic [5:0]  bit_cnt;

    logic        full;
    logic        xfer;
    logic        stall;
    logic        sample_tick;
    logic        emit;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SEED;
            SEED:    if (seed_cnt == SEED_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    // A full word that cannot be handed off stalls sampling so no pair is split.
    always_comb begin
        full        = (bit_cnt == 6'd32);
        xfer        = full && (!rnd_valid || rnd_ack);
        stall       = full && !xfer;
        sample_tick = (state == RUN) && enable && !stall && (sample_cnt == SAMPLE_LAST);
        emit        = sample_tick && pair_flag && (first_bit != sync2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            loop_ctrl <= 1'b1;
            loop_seed <= 1'b0;
            seed_cnt  <= 8'd0;
        end else begin
            state     <= state_next;
            loop_ctrl <= (state_next != RUN);
            if (state == IDLE && enable) loop_seed <= !loop_seed;
            if (state == SEED && enable)
                seed_cnt <= (seed_cnt == SEED_LAST) ? 8'd0 : seed_cnt + 8'd1;
            else
                seed_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= loop_d;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= 8'd0;
            pair_flag  <= 1'b0;
            first_bit  <= 1'b0;
        end else if (!enable || state != RUN) begin
            sample_cnt <= 8'd0;
            pair_flag  <= 1'b0;
        end else if (!stall) begin
            sample_cnt <= (sample_cnt == SAMPLE_LAST) ? 8'd0 : sample_cnt + 8'd1;
            if (sample_tick) begin
                pair_flag <= !pair_flag;
                if (!pair_flag) first_bit <= sync2;
            end
        end
    end

    // A bit emitted on the transfer cycle becomes the first bit of the next word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collect <= 32'd0;
            bit_cnt <= 6'd0;
        end else if (!enable) begin
            collect <= 32'd0;
            bit_cnt <= 6'd0;
        end else begin
            if (emit) collect <= {collect[30:0], first_bit};
            if (xfer)
                bit_cnt <= emit ? 6'd1 : 6'd0;
            else if (emit)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd_data  <= 32'd0;
            rnd_valid <= 1'b0;
        end else if (xfer) begin
            rnd_data  <= collect;
            rnd_valid <= 1'b1;
        end else if (rnd_ack) begin
            rnd_valid <= 1'b0;
        end
    end

endmodule

// File: doc/loop_sampler.md
# loop_sampler

Controller and harvester for a five-stage ring-oscillator entropy loop. Drives the loop's `ctrl`/`seed` inputs through a seed-then-run sequence, synchronises and periodically samples the loop output, applies von Neumann debiasing, and packs the debiased bits into 32-bit words. Words are delivered over a valid/ack handshake to the entropy collector downstream.

## Interface
Parameters:
- `SAMPLE_CYCLES`, default 16: clk cycles between samples of the synchronised loop output. Legal range 2..255.
- `SEED_CYCLES`, default 4: clk cycles the loop is held in seed mode (`loop_ctrl`=1) before free-running. Legal range 1..255.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = run the loop and harvest; 0 = park the loop.
- `loop_d` in 1: ring-oscillator output. Asynchronous to `clk`.
- `loop_ctrl` out 1: loop control. 1 = seed/static, 0 = oscillate.
- `loop_seed` out 1: seed value applied while `loop_ctrl`=1.
- `rnd_data` out 32: harvested word.
- `rnd_valid` out 1: `rnd_data` holds an unconsumed word.
- `rnd_ack` in 1: consumer accepts the word. Only meaningful while `rnd_valid`=1.

## Operation
- **Synchroniser:** `loop_d` passes through two flops (`sync1` → `sync2`). Only `sync2` is ever sampled.
- **FSM states:** IDLE, SEED, RUN.
  - IDLE: `loop_ctrl`=1. Go to SEED when `enable`=1, inverting `loop_seed` on the same edge.
  - SEED: `loop_ctrl`=1. Seed counter runs 0..SEED_CYCLES-1; the cycle it reaches SEED_CYCLES-1, go to RUN.
  - RUN: `loop_ctrl`=0.
  - `enable`=0 in any state forces IDLE on the next edge. It also clears the sample counter, pair flag and collect register.
- **Sampling (RUN only):** the sample counter runs 0..SAMPLE_CYCLES-1 and wraps. When it equals SAMPLE_CYCLES-1, take a sample s = `sync2`.
- **Von Neumann pairing:**
  - The pair flag toggles on every sample.
  - First sample of a pair: store it as `a`.
  - Second sample (`b`): if a≠b, emit bit `a`. If a=b, emit nothing.
- **Collect register (32 bits) and bit counter (0..32):**
  - An emitted bit is shifted in at the LSB, shifting left; the first bit of a word ends at bit 31.
  - When the counter reaches 32, the word is full.
- **Transfer:**
  - Condition: word full AND (`rnd_valid`=0 OR `rnd_ack`=1).
  - Action: copy the collect register to `rnd_data`, set `rnd_valid`=1, clear the bit counter.
- **Back-pressure:** while the word is full and no transfer is possible, the sample counter and pair flag freeze. The loop keeps oscillating and no samples are lost mid-pair.
- **Ack without transfer:** `rnd_ack`=1 while `rnd_valid`=1 clears `rnd_valid` on the next edge.
- **Simultaneous ack and transfer:** `rnd_valid` stays 1 and `rnd_data` updates to the new word.
- **Effect of `enable`=0 on the output:** it does not touch `rnd_valid`/`rnd_data`. A completed word survives until acked. A partial word is discarded.

## Timing
- **Reset values:**
  - Outputs: `loop_ctrl`=1, `loop_seed`=0, `rnd_data`=0, `rnd_valid`=0.
  - Internal: state IDLE, all counters 0, sync flops 0, pair flag 0.
- **IDLE → SEED:** one cycle after `enable` rises. SEED lasts exactly SEED_CYCLES cycles. `loop_ctrl` falls on the edge entering RUN.
- **First sample:** taken on RUN cycle SAMPLE_CYCLES (counting the first RUN cycle as 1).
- **Latency:** a bit present on `loop_d` reaches `sync2` 2 edges later.
- **`rnd_valid` rise:** on the edge after the sample that completes the word.
- **Minimum word time:** 64 samples, i.e. 64·SAMPLE_CYCLES RUN cycles.
- **Reset mid-operation:** asserting `reset_n` at any time returns every output to its reset value immediately (asynchronously).

## Test plan
- **Reset values:** assert `reset_n`=0 mid-RUN with `rnd_valid`=1 → immediately `loop_ctrl`=1, `loop_seed`=0, `rnd_valid`=0, `rnd_data`=0.
- **Seed sequence:** defaults; raise `enable` → `loop_seed` goes 0→1 and `loop_ctrl`=1 for 4 cycles, then 0. Drop and re-raise `enable` → `loop_seed` goes 1→0.
- **Constant input:** `loop_d` held at 1 for 5000 cycles in RUN → `rnd_valid` never asserts.
- **All-ones word:** bench drives `loop_d` so successive samples alternate 1,0 → after 64 samples (1024 RUN cycles + sync latency) `rnd_valid`=1 and `rnd_data`=0xFFFFFFFF. Repeat with pairs 0,1 → `rnd_data`=0x00000000.
- **Back-pressure:** no `rnd_ack`; second word completes → sampling freezes and `rnd_data` is unchanged. Pulse `rnd_ack` → next edge `rnd_data`=second word, `rnd_valid` stays 1. Pulse `rnd_ack` again → `rnd_valid`=0.
- **Enable drop:** drop `enable` after 20 emitted bits → IDLE and `loop_ctrl`=1 next cycle. After re-enabling, the next word needs a full 32 new bits, with no stale bits from the aborted word.
